instr_fetch: RTL and testbench

- Consumes the program counter value and fetches one instruction per PC value from a synchronous program memory.
- Presents each instruction downstream with a valid/ready handshake.
- After each accepted instruction, issues a one-cycle increment request back to the PC.
- The PC increments on the rising edge of that request, so the request must return low between increments.

---
 rtl/instr_fetch_pkg.sv | 18 +
 rtl/instr_fetch_if.sv | 33 +++
 rtl/sat_counter.sv | 23 ++
 rtl/instr_fetch.sv | 127 ++++++++++++
 tb/tb_instr_fetch.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch block.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package instr_fetch_pkg;

    // Fetch sequencer states, 3-bit encoding.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        DATA = 3'd2,
        HOLD = 3'd3,
        ADV  = 3'd4
    } fetch_state_t;

    // Width of the optional stall cycle counter.
    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/instr_fetch_if.sv
// Groups the program-memory read port and the downstream instruction handshake.
// Latency: n/a (wires only).
// Backpressure: instr_ready from the consumer; the memory side has none.
//
// Signals:
//   mem_en / mem_addr      read strobe and address toward program memory
//   mem_rdata              read data, valid one cycle after mem_en
//   instr_out / instr_pc   fetched instruction and the address it came from
//   instr_valid            instr_out / instr_pc are valid
//   instr_ready            consumer accepts
// Modports: master = fetch unit, slave = memory plus consumer.
interface instr_fetch_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] instr_out;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;

    modport master (
        output mem_en, mem_addr, instr_out, instr_pc, instr_valid,
        input  mem_rdata, instr_ready
    );

    modport slave (
        input  mem_en, mem_addr, instr_out, instr_pc, instr_valid,
        output mem_rdata, instr_ready
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc high and sticks at all-ones.
// Latency: count reflects an inc one cycle later.
// Backpressure: none; inc is sampled every cycle.
//
// Ports: clk, reset (async, active-high), inc (count enable), count (current value).
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && !(&count)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetches one instruction per PC value from synchronous program memory and hands it downstream.
// Latency: REQ to instr_valid is 2 cycles; best case one instruction every 4 cycles.
// Backpressure: holds instr_valid/instr_out stable until instr_ready; no PC increment until accepted.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   run               fetch enable (level), sampled in IDLE and ADV only
//   pc_in             current PC value
//   pc_incr           one-cycle increment request to the PC, issued after each accept
//   pc_wrap           one-cycle flag alongside pc_incr when pc_in is all-ones
//   bus               memory read port + instruction handshake (instr_fetch_if.master)
//   stall_cnt         saturating count of valid-but-not-ready cycles,
//                     present only with INSTR_FETCH_STALL_CNT_EN defined
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pc_incr,
    output logic              pc_wrap,
    instr_fetch_if.master     bus
`ifdef INSTR_FETCH_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [ADDR_W-1:0] req_addr_q;
    logic [DATA_W-1:0] instr_out_q;
    logic [ADDR_W-1:0] instr_pc_q;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic              instr_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and outputs. HOLD is the only state presenting valid, so
    // instr_valid cannot drop without a handshake. ADV lasts exactly one
    // cycle and is always separated from the next ADV by REQ/DATA/HOLD,
    // which keeps pc_incr low at least 3 cycles between pulses.
    always_comb begin
        state_d     = state_q;
        mem_en      = 1'b0;
        mem_addr    = '0;
        instr_valid = 1'b0;
        pc_incr     = 1'b0;
        pc_wrap     = 1'b0;
        case (state_q)
            IDLE: begin
                if (run) state_d = REQ;
            end
            REQ: begin
                mem_en   = 1'b1;
                mem_addr = pc_in;
                state_d  = DATA;
            end
            DATA: begin
                state_d = HOLD;
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (bus.instr_ready) state_d = ADV;
            end
            ADV: begin
                pc_incr = 1'b1;
                pc_wrap = &pc_in;
                state_d = run ? REQ : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The request address is remembered so instr_pc names exactly the
    // address that was read, independent of what pc_in does afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_addr_q  <= '0;
            instr_out_q <= '0;
            instr_pc_q  <= '0;
        end else begin
            if (state_q == REQ) begin
                req_addr_q <= pc_in;
            end
            // mem_rdata is only meaningful in DATA; ignored everywhere else.
            if (state_q == DATA) begin
                instr_out_q <= bus.mem_rdata;
                instr_pc_q  <= req_addr_q;
            end
        end
    end

    assign bus.mem_en      = mem_en;
    assign bus.mem_addr    = mem_addr;
    assign bus.instr_valid = instr_valid;
    assign bus.instr_out   = instr_out_q;
    assign bus.instr_pc    = instr_pc_q;

`ifdef INSTR_FETCH_STALL_CNT_EN
    logic stall_inc;
    assign stall_inc = instr_valid & ~bus.instr_ready;

    sat_counter #(
        .WIDTH (STALL_CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed vector table, hand-written corner sequences,
// randomized run/ready traffic checked against rule-level expectations.
// Environment: bench-side PC register and synchronous memory, driven #1 after each clock edge.
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic [7:0] pc_in;
    logic       pc_incr;
    logic       pc_wrap;
`ifdef INSTR_FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    instr_fetch_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    instr_fetch #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .pc_in   (pc_in),
        .pc_incr (pc_incr),
        .pc_wrap (pc_wrap),
        .bus     (bus)
`ifdef INSTR_FETCH_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    logic [15:0] mem [256];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int model_stall = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Called at a negedge; returns at the next negedge. Memory and PC react
    // to what the DUT presented during the cycle just ended.
    task automatic tick();
        logic       s_incr;
        logic       s_en;
        logic [7:0] s_addr;
        logic       s_stall;
        s_incr  = pc_incr;
        s_en    = bus.mem_en;
        s_addr  = bus.mem_addr;
        s_stall = bus.instr_valid && !bus.instr_ready;
        @(posedge clk);
        #1;
        if (reset) model_stall = 0;
        else if (s_stall === 1'b1 && model_stall < 65535) model_stall++;
        if (s_incr === 1'b1) pc_in = pc_in + 8'd1;
        bus.mem_rdata = (s_en === 1'b1) ? mem[s_addr] : 16'($urandom);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [7:0] start_pc);
        reset = 1'b1;
        model_stall = 0;
        pc_in = start_pc;
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [63:0] obs();
        return 64'({bus.mem_en, bus.mem_addr, bus.instr_valid, bus.instr_out,
                    bus.instr_pc, pc_incr, pc_wrap});
    endfunction

    typedef struct {
        bit          run;
        bit          rdy;
        logic [63:0] exp;
        logic [15:0] st;
    } vec_t;

    function automatic vec_t mk(bit r, bit rd, bit en, logic [7:0] a, bit v,
                                logic [15:0] o, logic [7:0] p, bit inc, bit wr,
                                logic [15:0] st);
        vec_t x;
        x.run = r;
        x.rdy = rd;
        x.exp = 64'({en, a, v, o, p, inc, wr});
        x.st  = st;
        return x;
    endfunction

    // Random-phase tracking state.
    typedef struct {
        int         due;
        logic [7:0] a;
    } fetch_t;
    fetch_t      fq[$];
    int          pend;
    int          last_incr;
    bit          prev_hs;
    bit          prev_stall;
    logic [15:0] prev_out;
    logic [7:0]  prev_ipc;

    task automatic rand_cycle();
        fetch_t f;
        if (pc_incr === 1'b1) begin
            chk("incr_after_accept", 64'(pend), 64'd1);
            chk("incr_gap", 64'((cyc - last_incr) >= 4), 64'd1);
            pend = 0;
            last_incr = cyc;
        end
        chk("wrap_rule", 64'(pc_wrap), 64'(pc_incr === 1'b1 && pc_in == 8'hFF));
        if (prev_hs) chk("valid_clear", 64'(bus.instr_valid), 64'd0);
        if (prev_stall)
            chk("hold_stable", 64'({bus.instr_valid, bus.instr_out, bus.instr_pc}),
                64'({1'b1, prev_out, prev_ipc}));
        if (bus.mem_en === 1'b1) begin
            chk("fetch_addr", 64'(bus.mem_addr), 64'(pc_in));
            f.due = cyc + 2;
            f.a   = bus.mem_addr;
            fq.push_back(f);
        end
        if (fq.size() > 0 && fq[0].due == cyc) begin
            f = fq.pop_front();
            chk("fetch_latency", 64'({bus.instr_valid, bus.instr_pc}), 64'({1'b1, f.a}));
            chk("instr_data", 64'(bus.instr_out), 64'(mem[f.a]));
        end
`ifdef INSTR_FETCH_STALL_CNT_EN
        chk("stall_cnt_rand", 64'(stall_cnt), 64'(model_stall));
`endif
        prev_hs    = (bus.instr_valid === 1'b1) && bus.instr_ready;
        prev_stall = (bus.instr_valid === 1'b1) && !bus.instr_ready;
        prev_out   = bus.instr_out;
        prev_ipc   = bus.instr_pc;
        if (prev_hs) pend++;
        tick();
    endtask

    initial begin
        vec_t tbl[19];
        int   n_incr;
        int   n_en;
        int   n_vld;

        reset = 1'b1;
        run = 1'b0;
        pc_in = 8'h00;
        bus.instr_ready = 1'b0;
        bus.mem_rdata = 16'h0;
        for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
        @(negedge clk);

        // Reset state while reset is held.
        run = 1'b1;
        bus.instr_ready = 1'b1;
        tick();
        chk("reset_outputs", obs(), 64'd0);

        // Directed table: two back-to-back fetches, then a 5-cycle stall.
        tbl[0]  = mk(1, 1, 0, 8'h00, 0, 16'h0000, 8'h00, 0, 0, 16'd0); // IDLE
        tbl[1]  = mk(1, 1, 1, 8'h00, 0, 16'h0000, 8'h00, 0, 0, 16'd0); // REQ
        tbl[2]  = mk(1, 1, 0, 8'h00, 0, 16'h0000, 8'h00, 0, 0, 16'd0); // DATA
        tbl[3]  = mk(1, 1, 0, 8'h00, 1, 16'hA000, 8'h00, 0, 0, 16'd0); // HOLD
        tbl[4]  = mk(1, 1, 0, 8'h00, 0, 16'hA000, 8'h00, 1, 0, 16'd0); // ADV
        tbl[5]  = mk(1, 1, 1, 8'h01, 0, 16'hA000, 8'h00, 0, 0, 16'd0);
        tbl[6]  = mk(1, 1, 0, 8'h00, 0, 16'hA000, 8'h00, 0, 0, 16'd0);
        tbl[7]  = mk(1, 1, 0, 8'h00, 1, 16'hA001, 8'h01, 0, 0, 16'd0);
        tbl[8]  = mk(1, 1, 0, 8'h00, 0, 16'hA001, 8'h01, 1, 0, 16'd0);
        tbl[9]  = mk(1, 0, 1, 8'h02, 0, 16'hA001, 8'h01, 0, 0, 16'd0);
        tbl[10] = mk(1, 0, 0, 8'h00, 0, 16'hA001, 8'h01, 0, 0, 16'd0);
        tbl[11] = mk(1, 0, 0, 8'h00, 1, 16'hA002, 8'h02, 0, 0, 16'd0);
        tbl[12] = mk(1, 0, 0, 8'h00, 1, 16'hA002, 8'h02, 0, 0, 16'd1);
        tbl[13] = mk(1, 0, 0, 8'h00, 1, 16'hA002, 8'h02, 0, 0, 16'd2);
        tbl[14] = mk(1, 0, 0, 8'h00, 1, 16'hA002, 8'h02, 0, 0, 16'd3);
        tbl[15] = mk(1, 0, 0, 8'h00, 1, 16'hA002, 8'h02, 0, 0, 16'd4);
        tbl[16] = mk(1, 1, 0, 8'h00, 1, 16'hA002, 8'h02, 0, 0, 16'd5);
        tbl[17] = mk(1, 1, 0, 8'h00, 0, 16'hA002, 8'h02, 1, 0, 16'd5);
        tbl[18] = mk(1, 1, 1, 8'h03, 0, 16'hA002, 8'h02, 0, 0, 16'd5);

        do_reset(8'h00);
        for (int i = 0; i < 19; i++) begin
            run = tbl[i].run;
            bus.instr_ready = tbl[i].rdy;
            chk($sformatf("vec%0d", i), obs(), tbl[i].exp);
`ifdef INSTR_FETCH_STALL_CNT_EN
            chk($sformatf("vec%0d_stall", i), 64'(stall_cnt), 64'(tbl[i].st));
`endif
            tick();
        end

        // PC wrap: fetch from 0xFF, increment flagged, next fetch from 0x00.
        run = 1'b1;
        bus.instr_ready = 1'b1;
        do_reset(8'hFF);
        tick();
        chk("wrap_req", 64'({bus.mem_en, bus.mem_addr}), 64'({1'b1, 8'hFF}));
        tick();
        tick();
        chk("wrap_instr", 64'({bus.instr_valid, bus.instr_out, bus.instr_pc}),
            64'({1'b1, 16'hA0FF, 8'hFF}));
        tick();
        chk("wrap_pulse", 64'({pc_incr, pc_wrap}), 64'(2'b11));
        tick();
        chk("wrap_next", 64'({bus.mem_en, bus.mem_addr, pc_wrap}), 64'({1'b1, 8'h00, 1'b0}));

        // run dropped during DATA: instruction completes, then parks.
        do_reset(8'h10);
        tick();
        tick();
        run = 1'b0;
        tick();
        chk("drop_instr", 64'({bus.instr_valid, bus.instr_out, bus.instr_pc}),
            64'({1'b1, 16'hA010, 8'h10}));
        tick();
        chk("drop_incr", 64'(pc_incr), 64'd1);
        tick();
        n_incr = 0;
        n_en = 0;
        n_vld = 0;
        for (int i = 0; i < 8; i++) begin
            n_incr += int'(pc_incr);
            n_en   += int'(bus.mem_en);
            n_vld  += int'(bus.instr_valid);
            tick();
        end
        chk("drop_parked", 64'({n_incr[7:0], n_en[7:0], n_vld[7:0]}), 64'd0);
        chk("drop_pc", 64'(pc_in), 64'h11);

        // Reset asserted in HOLD: async clear, no increment, restart from PC.
        run = 1'b1;
        bus.instr_ready = 1'b0;
        do_reset(8'h20);
        tick();
        tick();
        tick();
        chk("hold_before_reset", 64'(bus.instr_valid), 64'd1);
        tick();
        reset = 1'b1;
        model_stall = 0;
        #1;
        chk("async_reset", obs(), 64'd0);
        tick();
        tick();
        tick();
        chk("no_incr_on_reset", 64'(pc_in), 64'h20);
`ifdef INSTR_FETCH_STALL_CNT_EN
        chk("stall_cleared", 64'(stall_cnt), 64'd0);
`endif
        reset = 1'b0;
        bus.instr_ready = 1'b1;
        tick();
        chk("restart_req", 64'({bus.mem_en, bus.mem_addr}), 64'({1'b1, 8'h20}));
        tick();
        tick();
        chk("restart_instr", 64'({bus.instr_valid, bus.instr_out, bus.instr_pc}),
            64'({1'b1, 16'hA020, 8'h20}));

        // Randomized run/ready traffic over random memory contents.
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        run = 1'b1;
        bus.instr_ready = 1'b1;
        do_reset(8'($urandom));
        fq.delete();
        pend = 0;
        last_incr = -100;
        prev_hs = 1'b0;
        prev_stall = 1'b0;
        prev_out = '0;
        prev_ipc = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) run = ~run;
            bus.instr_ready = ($urandom_range(0, 3) != 0);
            rand_cycle();
        end
        run = 1'b0;
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 20; i++) rand_cycle();
        chk("drain_pending", 64'({pend[7:0], 8'(fq.size())}), 64'd0);
        chk("drain_idle", 64'({bus.mem_en, bus.instr_valid, pc_incr}), 64'd0);

`ifdef INSTR_FETCH_STALL_CNT_EN
        // Long stall: counter saturates and stays at all-ones.
        run = 1'b1;
        bus.instr_ready = 1'b0;
        do_reset(8'h00);
        tick();
        tick();
        tick();
        for (int i = 0; i < 70000; i++) tick();
        chk("stall_saturate", 64'(stall_cnt), 64'hFFFF);
        chk("stall_model", 64'(model_stall), 64'hFFFF);
        tick();
        tick();
        chk("stall_no_wrap", 64'(stall_cnt), 64'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
